// File: rtl/axi_slave_mem_burst.sv
// AXI4 slave backed by on-chip word memory: FIXED/INCR/WRAP bursts, byte strobes,
// SLVERR on out-of-range beats or illegal bursts; one outstanding burst per direction.
module axi_slave_mem_burst #(
  parameter int              AXI_ID_WIDTH     = 2,
  parameter int              AXI_DATA_WIDTH   = 32,
  parameter int              AXI_ADDR_WIDTH   = 32,
  parameter int              AXI_USER_WIDTH   = 10,
  parameter int              DATA_MEM_LENGTH  = 8192,
  parameter longint unsigned ADDR_BASE_OFFSET = 0,
  parameter longint unsigned ADDR_END         = 'h10000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [AXI_ID_WIDTH-1:0]   AXI_slave_awid,
  input  logic [AXI_ADDR_WIDTH-1:0] AXI_slave_awaddr,
  input  logic [7:0]                AXI_slave_awlen,
  input  logic [2:0]                AXI_slave_awsize,
  input  logic [1:0]                AXI_slave_awburst,
  input  logic                      AXI_slave_awlock,
  input  logic [3:0]                AXI_slave_awcache,
  input  logic [2:0]                AXI_slave_awprot,
  input  logic [3:0]                AXI_slave_awqos,
  input  logic [3:0]                AXI_slave_awregion,
  input  logic [AXI_USER_WIDTH-1:0] AXI_slave_awuser,
  input  logic                      AXI_slave_awvalid,
  output logic                      AXI_slave_awready,
  input  logic [AXI_DATA_WIDTH-1:0] AXI_slave_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] AXI_slave_wstrb,
  input  logic                      AXI_slave_wlast,
  input  logic [AXI_USER_WIDTH-1:0] AXI_slave_wuser,
  input  logic                      AXI_slave_wvalid,
  output logic                      AXI_slave_wready,
  output logic [AXI_ID_WIDTH-1:0]   AXI_slave_bid,
  output logic [1:0]                AXI_slave_bresp,
  output logic [AXI_USER_WIDTH-1:0] AXI_slave_buser,
  output logic                      AXI_slave_bvalid,
  input  logic                      AXI_slave_bready,
  input  logic [AXI_ID_WIDTH-1:0]   AXI_slave_arid,
  input  logic [AXI_ADDR_WIDTH-1:0] AXI_slave_araddr,
  input  logic [7:0]                AXI_slave_arlen,
  input  logic [2:0]                AXI_slave_arsize,
  input  logic [1:0]                AXI_slave_arburst,
  input  logic                      AXI_slave_arlock,
  input  logic [3:0]                AXI_slave_arcache,
  input  logic [2:0]                AXI_slave_arprot,
  input  logic [3:0]                AXI_slave_arqos,
  input  logic [3:0]                AXI_slave_arregion,
  input  logic [AXI_USER_WIDTH-1:0] AXI_slave_aruser,
  input  logic                      AXI_slave_arvalid,
  output logic                      AXI_slave_arready,
  output logic [AXI_ID_WIDTH-1:0]   AXI_slave_rid,
  output logic [AXI_DATA_WIDTH-1:0] AXI_slave_rdata,
  output logic [1:0]                AXI_slave_rresp,
  output logic                      AXI_slave_rlast,
  output logic [AXI_USER_WIDTH-1:0] AXI_slave_ruser,
  output logic                      AXI_slave_rvalid,
  input  logic                      AXI_slave_rready
);

  localparam int AW       = AXI_ADDR_WIDTH;
  localparam int DW       = AXI_DATA_WIDTH;
  localparam int BYTES    = DW / 8;
  localparam int ADDR_LSB = $clog2(BYTES);
  localparam int IDX_W    = (DATA_MEM_LENGTH > 1) ? $clog2(DATA_MEM_LENGTH) : 1;
  localparam logic [AW-1:0] BASE_A = AW'(ADDR_BASE_OFFSET);
  localparam logic [AW-1:0] SPAN_A = AW'(ADDR_END - ADDR_BASE_OFFSET);
  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;

  // Below-base addresses wrap to a huge offset, so one compare covers both bounds.
  function automatic logic in_range(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = a - BASE_A;
    return off < SPAN_A;
  endfunction

  function automatic logic [IDX_W-1:0] mem_idx(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = a - BASE_A;
    return IDX_W'((off >> ADDR_LSB) % AW'(DATA_MEM_LENGTH));
  endfunction

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
    logic [AW-1:0] inc, span, lo, nx;
    inc  = AW'(1) << size;
    span = (AW'(len) + AW'(1)) << size;
    lo   = a & ~(span - AW'(1));
    nx   = a + inc;
    case (burst)
      2'd1:    ;
      2'd2:    if (nx == lo + span) nx = lo;
      default: nx = a;
    endcase
    return nx;
  endfunction

  function automatic logic bad_burst(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    return (burst == 2'd3) || (size > 3'(ADDR_LSB)) ||
           ((burst == 2'd2) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  logic [DW-1:0] mem_q [DATA_MEM_LENGTH];

  // ---------------- write channel ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  wstate_e                 w_state_q, w_state_d;
  logic [AW-1:0]           waddr_q, waddr_d;
  logic [7:0]              wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [2:0]              wsize_q, wsize_d;
  logic [1:0]              wburst_q, wburst_d;
  logic [AXI_ID_WIDTH-1:0] bid_q, bid_d;
  logic                    werr_q, werr_d;
  logic                    mem_we, w_beat_err;
  logic [IDX_W-1:0]        widx;

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      bid_q     <= '0;
      werr_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      wsize_q   <= wsize_d;
      wburst_q  <= wburst_d;
      bid_q     <= bid_d;
      werr_q    <= werr_d;
    end
  end

  always_comb begin
    w_state_d  = w_state_q;
    waddr_d    = waddr_q;
    wlen_d     = wlen_q;
    wcnt_d     = wcnt_q;
    wsize_d    = wsize_q;
    wburst_d   = wburst_q;
    bid_d      = bid_q;
    werr_d     = werr_q;
    mem_we     = 1'b0;
    AXI_slave_awready = 1'b0;
    AXI_slave_wready  = 1'b0;
    AXI_slave_bvalid  = 1'b0;
    widx       = mem_idx(waddr_q);
    w_beat_err = !in_range(waddr_q) || (AXI_slave_wlast != (wcnt_q == wlen_q));
    case (w_state_q)
      W_IDLE: begin
        AXI_slave_awready = !reset;
        if (AXI_slave_awvalid) begin
          waddr_d   = AXI_slave_awaddr;
          wlen_d    = AXI_slave_awlen;
          wsize_d   = AXI_slave_awsize;
          wburst_d  = AXI_slave_awburst;
          bid_d     = AXI_slave_awid;
          wcnt_d    = '0;
          werr_d    = bad_burst(AXI_slave_awlen, AXI_slave_awsize, AXI_slave_awburst);
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        AXI_slave_wready = 1'b1;
        if (AXI_slave_wvalid) begin
          // Once a burst is flagged, no later beat of it touches memory.
          mem_we  = !werr_q && !w_beat_err;
          werr_d  = werr_q || w_beat_err;
          waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
          wcnt_d  = wcnt_q + 8'd1;
          if (wcnt_q == wlen_q) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        AXI_slave_bvalid = 1'b1;
        if (AXI_slave_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      for (int b = 0; b < BYTES; b++)
        if (AXI_slave_wstrb[b]) mem_q[widx][8*b +: 8] <= AXI_slave_wdata[8*b +: 8];
    end
  end

  assign AXI_slave_bid   = bid_q;
  assign AXI_slave_bresp = (w_state_q == W_RESP && werr_q) ? RESP_SLVERR : RESP_OKAY;
  assign AXI_slave_buser = '0;

  // ---------------- read channel ----------------
  typedef enum logic {R_IDLE, R_DATA} rstate_e;
  rstate_e                 r_state_q, r_state_d;
  logic [AW-1:0]           raddr_q, raddr_d, ld_addr;
  logic [7:0]              rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [2:0]              rsize_q, rsize_d;
  logic [1:0]              rburst_q, rburst_d;
  logic [AXI_ID_WIDTH-1:0] rid_q, rid_d;
  logic                    rbad_q, rbad_d, ld_bad, ld_err, r_load;
  logic [DW-1:0]           rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
      rid_q     <= '0;
      rbad_q    <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      rsize_q   <= rsize_d;
      rburst_q  <= rburst_d;
      rid_q     <= rid_d;
      rbad_q    <= rbad_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Beat data is captured into rdata_q at the edge that starts the beat, so it
  // stays stable under backpressure and a same-edge write is seen as old data.
  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    rid_d     = rid_q;
    rbad_d    = rbad_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    r_load    = 1'b0;
    ld_addr   = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
    ld_bad    = rbad_q;
    AXI_slave_arready = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        AXI_slave_arready = !reset;
        if (AXI_slave_arvalid) begin
          ld_addr   = AXI_slave_araddr;
          ld_bad    = bad_burst(AXI_slave_arlen, AXI_slave_arsize, AXI_slave_arburst);
          raddr_d   = AXI_slave_araddr;
          rlen_d    = AXI_slave_arlen;
          rsize_d   = AXI_slave_arsize;
          rburst_d  = AXI_slave_arburst;
          rid_d     = AXI_slave_arid;
          rbad_d    = ld_bad;
          rcnt_d    = '0;
          r_load    = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (AXI_slave_rready) begin
          if (rcnt_q == rlen_q) begin
            r_state_d = R_IDLE;
          end else begin
            raddr_d = ld_addr;
            rcnt_d  = rcnt_q + 8'd1;
            r_load  = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    ld_err = ld_bad || !in_range(ld_addr);
    if (r_load) begin
      rdata_d = ld_err ? '0 : mem_q[mem_idx(ld_addr)];
      rresp_d = ld_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign AXI_slave_rvalid = (r_state_q == R_DATA);
  assign AXI_slave_rlast  = (r_state_q == R_DATA) && (rcnt_q == rlen_q);
  assign AXI_slave_rdata  = rdata_q;
  assign AXI_slave_rresp  = rresp_q;
  assign AXI_slave_rid    = rid_q;
  assign AXI_slave_ruser  = '0;

  logic unused_sideband;
  assign unused_sideband = ^{AXI_slave_awlock, AXI_slave_awcache, AXI_slave_awprot,
                             AXI_slave_awqos, AXI_slave_awregion, AXI_slave_awuser,
                             AXI_slave_wuser, AXI_slave_arlock, AXI_slave_arcache,
                             AXI_slave_arprot, AXI_slave_arqos, AXI_slave_arregion,
                             AXI_slave_aruser};

endmodule
